// File: rtl/product_accumulator_if.sv
// Product/result handshake bundle for product_accumulator.
// master drives products and takes results; slave is the accumulator itself.
interface product_accumulator_if #(
   parameter int ACC_W = 12
);
   logic [7:0]       product;
   logic             in_valid;
   logic             in_ready;
   logic             clear;
   logic [ACC_W-1:0] sum;
   logic             overflow;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output product, in_valid, clear, out_ready,
      input  in_ready, sum, overflow, out_valid
   );

   modport slave (
      input  product, in_valid, clear, out_ready,
      output in_ready, sum, overflow, out_valid
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN unsigned 8-bit products per result and holds the result until it is taken.
// Define PRODUCT_ACC_SATURATE_EN to clamp at 2^ACC_W-1 on overflow instead of wrapping.
//
// state  | meaning
// S_ACC  | collecting products, in_ready=1 (unless reset was seen last edge)
// S_HOLD | presenting sum/overflow, out_valid=1
module product_accumulator #(
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   product_accumulator_if.slave  bus
);

   localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
`ifdef PRODUCT_ACC_SATURATE_EN
   localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

   typedef enum logic {
      S_ACC  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0] cnt;
   logic             flag;
   logic             flag_nxt;
   logic             ovf_q;
   logic             rst_hold;
   logic [ACC_W:0]   add_ext;
   logic             accept;
   logic             last;
   logic             in_ready_c;
   logic             out_valid_c;

   assign accept  = bus.in_valid & in_ready_c;
   assign last    = (cnt == LAST_CNT);
   assign add_ext = {1'b0, acc} + (ACC_W+1)'(bus.product);

   always_comb begin
      flag_nxt = flag | add_ext[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
      // once clamped, stay clamped until the block ends
      acc_nxt  = (add_ext[ACC_W] | flag) ? ACC_MAX : add_ext[ACC_W-1:0];
`else
      acc_nxt  = add_ext[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // keeps in_ready low for the cycle following any reset edge
   always_ff @(posedge clk) begin
      rst_hold <= ~rst_n;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ACC: begin
            if (!bus.clear && accept && last) begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.clear || bus.out_ready) begin
               state_nxt = S_ACC;
            end
         end
         default: state_nxt = S_ACC;
      endcase
   end

   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         S_ACC:   in_ready_c  = ~rst_hold;
         S_HOLD:  out_valid_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         flag  <= 1'b0;
         sum_q <= '0;
         ovf_q <= 1'b0;
      end else if (state == S_ACC) begin
         if (bus.clear) begin
            acc  <= '0;
            cnt  <= '0;
            flag <= 1'b0;
         end else if (accept) begin
            if (last) begin
               sum_q <= acc_nxt;
               ovf_q <= flag_nxt;
               acc   <= '0;
               cnt   <= '0;
               flag  <= 1'b0;
            end else begin
               acc  <= acc_nxt;
               cnt  <= cnt + 1'b1;
               flag <= flag_nxt;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed block scenarios plus random traffic against a block-sum model.
module tb_product_accumulator;

   localparam int ACC_W       = 12;
   localparam int BLOCK_LEN   = 4;
   localparam int ACC_W_B     = 8;
   localparam int BLOCK_LEN_B = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_nb;

   int n_tests = 0;
   int n_fail  = 0;

   product_accumulator_if #(.ACC_W(ACC_W))   bus_a ();
   product_accumulator_if #(.ACC_W(ACC_W_B)) bus_b ();

   product_accumulator #(.ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   product_accumulator #(.ACC_W(ACC_W_B), .BLOCK_LEN(BLOCK_LEN_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   // reference: queue of accepted products, result = arithmetic total of a full block
   bit m_hold = 1'b0;
   bit m_rsth = 1'b1;
   bit m_acc  = 1'b0;
   int m_q[$];
   int m_sum = 0;
   int m_ovf = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      bit rdy;
      int total;
      int lim;
      @(posedge clk);
      m_acc = 1'b0;
      if (!rst_n) begin
         m_hold = 1'b0;
         m_q.delete();
         m_sum  = 0;
         m_ovf  = 0;
         m_rsth = 1'b1;
      end else begin
         rdy    = !m_hold && !m_rsth;
         m_rsth = 1'b0;
         if (!m_hold) begin
            if (bus_a.clear) begin
               m_q.delete();
            end else if (bus_a.in_valid && rdy) begin
               m_acc = 1'b1;
               m_q.push_back(int'(bus_a.product));
               if (m_q.size() == BLOCK_LEN) begin
                  total = 0;
                  foreach (m_q[i]) total += m_q[i];
                  lim   = (1 << ACC_W) - 1;
                  m_ovf = (total > lim) ? 1 : 0;
`ifdef PRODUCT_ACC_SATURATE_EN
                  m_sum = (total > lim) ? lim : total;
`else
                  m_sum = total % (lim + 1);
`endif
                  m_q.delete();
                  m_hold = 1'b1;
               end
            end
         end else if (bus_a.clear || bus_a.out_ready) begin
            m_hold = 1'b0;
         end
      end
      #1;
      chk("in_ready",  int'(bus_a.in_ready),  int'(!m_hold && !m_rsth));
      chk("out_valid", int'(bus_a.out_valid), int'(m_hold));
      chk("sum",       int'(bus_a.sum),       m_sum);
      chk("overflow",  int'(bus_a.overflow),  m_ovf);
   endtask

   task automatic feed(input int p);
      bit got;
      got = 1'b0;
      bus_a.product  = 8'(p);
      bus_a.in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (m_acc) begin
            got = 1'b1;
            break;
         end
      end
      bus_a.in_valid = 1'b0;
      if (!got) chk("feed_timeout", 0, 1);
   endtask

   task automatic release_a();
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
   endtask

   task automatic pair_b(input int p0, input int p1, input int exp_sum, input int exp_ovf, input string tag);
      bus_b.in_valid = 1'b1;
      bus_b.product  = 8'(p0);
      tick();
      bus_b.product  = 8'(p1);
      tick();
      bus_b.in_valid = 1'b0;
      chk({tag, "_valid"}, int'(bus_b.out_valid), 1);
      chk({tag, "_sum"},   int'(bus_b.sum),       exp_sum);
      chk({tag, "_ovf"},   int'(bus_b.overflow),  exp_ovf);
      bus_b.out_ready = 1'b1;
      tick();
      bus_b.out_ready = 1'b0;
      chk({tag, "_release"}, int'(bus_b.out_valid), 0);
      chk({tag, "_ready"},   int'(bus_b.in_ready),  1);
   endtask

   initial begin
      rst_n  = 1'b0;
      rst_nb = 1'b0;
      bus_a.product = 8'd0; bus_a.in_valid = 1'b0; bus_a.clear = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.product = 8'd0; bus_b.in_valid = 1'b0; bus_b.clear = 1'b0; bus_b.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready",  int'(bus_a.in_ready),  0);
      chk("rst_out_valid", int'(bus_a.out_valid), 0);
      chk("rst_sum",       int'(bus_a.sum),       0);
      rst_n  = 1'b1;
      rst_nb = 1'b1;
      tick();
      chk("rel_in_ready", int'(bus_a.in_ready), 1);

      // four back-to-back products, result one cycle after the last accept
      feed(117); feed(42); feed(117);
      chk("r031_early", int'(bus_a.out_valid), 0);
      feed(42);
      chk("r031_valid", int'(bus_a.out_valid), 1);
      chk("r031_sum",   int'(bus_a.sum),       318);
      chk("r031_ovf",   int'(bus_a.overflow),  0);

      // backpressure
      bus_a.in_valid = 1'b1;
      repeat (5) begin
         tick();
         chk("r032_in_ready", int'(bus_a.in_ready), 0);
         chk("r032_sum",      int'(bus_a.sum),      318);
      end
      bus_a.in_valid = 1'b0;
      release_a();
      chk("r032_out_valid", int'(bus_a.out_valid), 0);
      chk("r032_in_ready1", int'(bus_a.in_ready),  1);

      // clear mid-block with a simultaneous valid product
      feed(117); feed(42);
      bus_a.clear = 1'b1; bus_a.in_valid = 1'b1; bus_a.product = 8'd117;
      tick();
      bus_a.clear = 1'b0; bus_a.in_valid = 1'b0;
      feed(1); feed(2); feed(3); feed(4);
      chk("r034_sum", int'(bus_a.sum), 10);
      release_a();

      // reset while holding a result
      feed(5); feed(6); feed(7); feed(8);
      rst_n = 1'b0;
      tick();
      chk("r035_out_valid", int'(bus_a.out_valid), 0);
      rst_n = 1'b1;
      tick();
      feed(255); feed(255); feed(255); feed(255);
      chk("r035_sum", int'(bus_a.sum),      1020);
      chk("r035_ovf", int'(bus_a.overflow), 0);
      release_a();

      // gapped valid
      for (int k = 0; k < 4; k++) begin
         feed(9);
         if (k < 3) begin
            tick();
            chk("r036_no_early", int'(bus_a.out_valid), 0);
         end
      end
      chk("r036_sum", int'(bus_a.sum), 36);
      release_a();

      // narrow instance: overflow handling and flag reset between blocks
`ifdef PRODUCT_ACC_SATURATE_EN
      pair_b(200, 100, 255, 1, "b_200_100");
      pair_b(100, 50,  150, 0, "b_100_50");
      pair_b(255, 255, 255, 1, "b_255_255");
`else
      pair_b(200, 100, 44,  1, "b_200_100");
      pair_b(100, 50,  150, 0, "b_100_50");
      pair_b(255, 255, 254, 1, "b_255_255");
`endif

      for (int n = 0; n < 3000; n++) begin
         rst_n           = ($urandom_range(0, 149) != 0);
         bus_a.clear     = ($urandom_range(0, 29) == 0);
         bus_a.in_valid  = ($urandom_range(0, 2) != 0);
         bus_a.product   = 8'($urandom_range(0, 255));
         bus_a.out_ready = ($urandom_range(0, 1) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
